// File: rtl/pc_fetch_unit_if.sv
// Control-to-fetch bus for pc_fetch_unit: next-PC controls in, PC/ROM strobe/status out.
interface pc_fetch_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic             pc_wre;
  logic [1:0]       pc_src;
  logic [31:0]      imm_ext;
  logic [25:0]      jaddr;
  logic [31:0]      rs_data;
  logic             halt_req;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic             nrd;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] retired;

  // master = decode/control side, slave = fetch unit
  modport master (
    output pc_wre, pc_src, imm_ext, jaddr, rs_data, halt_req,
    input  pc, pc_plus4, nrd, halted, fault, retired
  );

  modport slave (
    input  pc_wre, pc_src, imm_ext, jaddr, rs_data, halt_req,
    output pc, pc_plus4, nrd, halted, fault, retired
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register, next-PC select and fetch sequencing (BOOT/RUN/HALT/FAULT) ahead of the ROM.
// Optional macro PC_ALIGN_CHECK_EN: misaligned next-PC faults instead of being truncated.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_BYTES = 100,
  parameter int unsigned CNT_W     = 16
) (
  input logic              clk,
  input logic              nrst,
  pc_fetch_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // Range checks use 33 bits so addresses near 2^32 cannot wrap into the ROM
  localparam bit BOOT_BAD = ({1'b0, RESET_PC} + 33'd3) >= 33'(ROM_BYTES);

  state_e           state_q;
  logic [31:0]      pc_q;
  logic [31:0]      pc_plus4_q;
  logic [CNT_W-1:0] retired_q;
  logic             nrd_q;
  logic             halted_q;
  logic             fault_q;

  logic [31:0]      pc_d;
  logic             align_err;
  logic             range_err;

  // Next-PC select and commit checks
  always_comb begin
    pc_d = pc_plus4_q;
    unique case (bus.pc_src)
      2'b00:   pc_d = pc_plus4_q;
      2'b01:   pc_d = pc_plus4_q + (bus.imm_ext << 2);
      2'b10:   pc_d = {pc_plus4_q[31:28], bus.jaddr, 2'b00};
      default: pc_d = bus.rs_data;
    endcase
`ifdef PC_ALIGN_CHECK_EN
    align_err = |pc_d[1:0];
`else
    pc_d[1:0] = 2'b00;
    align_err = 1'b0;
`endif
    range_err = ({1'b0, pc_d} + 33'd3) >= 33'(ROM_BYTES);
  end

  // Fetch FSM with registered outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + 32'd4;
      retired_q  <= '0;
      nrd_q      <= 1'b1;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_BOOT: begin
          if (BOOT_BAD) begin
            state_q  <= ST_FAULT;
            halted_q <= 1'b1;
            fault_q  <= 1'b1;
          end else begin
            state_q <= ST_RUN;
            nrd_q   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.halt_req) begin
            state_q  <= ST_HALT;
            nrd_q    <= 1'b1;
            halted_q <= 1'b1;
          end else if (bus.pc_wre) begin
            if (align_err || range_err) begin
              state_q  <= ST_FAULT;
              nrd_q    <= 1'b1;
              halted_q <= 1'b1;
              fault_q  <= 1'b1;
            end else begin
              pc_q       <= pc_d;
              pc_plus4_q <= pc_d + 32'd4;
              if (retired_q != '1) retired_q <= retired_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4_q;
  assign bus.retired  = retired_q;
  assign bus.nrd      = nrd_q;
  assign bus.halted   = halted_q;
  assign bus.fault    = fault_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus queues expected state, monitor compares on sample events.
module tb_pc_fetch_unit;
  localparam int unsigned CNT_W = 4;

  typedef struct {
    string            nm;
    logic [31:0]      pc;
    logic [CNT_W-1:0] ret;
    logic             nrd;
    logic             halted;
    logic             fault;
  } exp_t;

  logic clk;
  logic nrst;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  event sample_ev;

  pc_fetch_unit_if #(.CNT_W(CNT_W)) bus ();

  pc_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .ROM_BYTES(100),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, field, act, exp);
    end
  endtask

  // Monitor: pops one expectation per presented sample
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor: sample with empty scoreboard");
      end else begin
        e = q.pop_front();
        chk(e.nm, "pc",       bus.pc,       e.pc);
        chk(e.nm, "pc_plus4", bus.pc_plus4, e.pc + 32'd4);
        chk(e.nm, "retired",  32'(bus.retired), 32'(e.ret));
        chk(e.nm, "nrd",      32'(bus.nrd),     32'(e.nrd));
        chk(e.nm, "halted",   32'(bus.halted),  32'(e.halted));
        chk(e.nm, "fault",    32'(bus.fault),   32'(e.fault));
      end
    end
  end

  task automatic push(input string nm, input logic [31:0] pc, input logic [CNT_W-1:0] ret,
                      input logic nrd, input logic h, input logic f);
    exp_t e;
    e.nm = nm; e.pc = pc; e.ret = ret; e.nrd = nrd; e.halted = h; e.fault = f;
    q.push_back(e);
  endtask

  // Drive at negedge, expect the state after the next posedge
  task automatic step(input string nm, input logic wre, input logic [1:0] src,
                      input logic [31:0] imm, input logic [25:0] ja, input logic [31:0] rs,
                      input logic hr, input logic [31:0] epc, input logic [CNT_W-1:0] eret,
                      input logic enrd, input logic eh, input logic ef);
    bus.pc_wre   = wre;
    bus.pc_src   = src;
    bus.imm_ext  = imm;
    bus.jaddr    = ja;
    bus.rs_data  = rs;
    bus.halt_req = hr;
    push(nm, epc, eret, enrd, eh, ef);
    @(posedge clk);
    #1 -> sample_ev;
    @(negedge clk);
  endtask

  task automatic do_reset(input string nm);
    nrst = 1'b0;
    #1;
    push(nm, 32'd0, '0, 1'b1, 1'b0, 1'b0);
    -> sample_ev;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0;
    bus.pc_wre = 1'b0; bus.pc_src = 2'b00; bus.imm_ext = '0;
    bus.jaddr = '0; bus.rs_data = '0; bus.halt_req = 1'b0;
    @(negedge clk);
    do_reset("reset0");

    // Sequential run, branch, jump, stall, then halt
    step("boot",   1, 2'b00, 0, 0, 0, 0, 32'd0,  4'd0, 0, 0, 0);
    step("seq1",   1, 2'b00, 0, 0, 0, 0, 32'd4,  4'd1, 0, 0, 0);
    step("seq2",   1, 2'b00, 0, 0, 0, 0, 32'd8,  4'd2, 0, 0, 0);
    step("seq3",   1, 2'b00, 0, 0, 0, 0, 32'd12, 4'd3, 0, 0, 0);
    step("jr8",    1, 2'b11, 0, 0, 32'd8, 0, 32'd8, 4'd4, 0, 0, 0);
    step("branch", 1, 2'b01, 32'hFFFF_FFFE, 0, 0, 0, 32'd4, 4'd5, 0, 0, 0);
    step("jump",   1, 2'b10, 0, 26'd5, 0, 0, 32'd20, 4'd6, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step("stall", 0, 2'b11, 0, 0, 32'd0, 0, 32'd20, 4'd6, 0, 0, 0);
    step("seq4",   1, 2'b00, 0, 0, 0, 0, 32'd24, 4'd7, 0, 0, 0);
    step("jr16",   1, 2'b11, 0, 0, 32'd16, 0, 32'd16, 4'd8, 0, 0, 0);
    step("halt",   1, 2'b00, 0, 0, 0, 1, 32'd16, 4'd8, 1, 1, 0);
    step("halt_t1", 1, 2'b11, 0, 0, 32'd40, 0, 32'd16, 4'd8, 1, 1, 0);
    step("halt_t2", 1, 2'b01, 32'd3, 0, 0, 1, 32'd16, 4'd8, 1, 1, 0);

    // Asynchronous reset between edges while running
    do_reset("reset1");
    step("boot1",  1, 2'b00, 0, 0, 0, 0, 32'd0, 4'd0, 0, 0, 0);
    step("seq1b",  1, 2'b00, 0, 0, 0, 0, 32'd4, 4'd1, 0, 0, 0);
    @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    push("async_rst", 32'd0, '0, 1'b1, 1'b0, 1'b0);
    -> sample_ev;
    @(negedge clk);
    nrst = 1'b1;

    // Out-of-range jr faults; faults are sticky
    step("boot2",  1, 2'b00, 0, 0, 0, 0, 32'd0, 4'd0, 0, 0, 0);
    step("jr100",  1, 2'b11, 0, 0, 32'd100, 0, 32'd0, 4'd0, 1, 1, 1);
    step("fault_t", 1, 2'b00, 0, 0, 0, 1, 32'd0, 4'd0, 1, 1, 1);

    // Misaligned jr: fault when alignment check is built in, else truncated
    do_reset("reset2");
    step("boot3",  1, 2'b00, 0, 0, 0, 0, 32'd0, 4'd0, 0, 0, 0);
    step("seq1c",  1, 2'b00, 0, 0, 0, 0, 32'd4, 4'd1, 0, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
    step("jr6",    1, 2'b11, 0, 0, 32'd6, 0, 32'd4, 4'd1, 1, 1, 1);
`else
    step("jr6",    1, 2'b11, 0, 0, 32'd6, 0, 32'd4, 4'd2, 0, 0, 0);
`endif

    // Counter saturation, last legal word (96), then range fault at 100
    do_reset("reset3");
    step("boot4",  1, 2'b00, 0, 0, 0, 0, 32'd0, 4'd0, 0, 0, 0);
    for (int i = 1; i <= 16; i++)
      step("sat", 1, 2'b00, 0, 0, 0, 0, 32'(4 * i), (i > 15) ? 4'd15 : 4'(i), 0, 0, 0);
    step("jr96",   1, 2'b11, 0, 0, 32'd96, 0, 32'd96, 4'd15, 0, 0, 0);
    step("seq100", 1, 2'b00, 0, 0, 0, 0, 32'd96, 4'd15, 1, 1, 1);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
